// File: rtl/systolic_pkg.sv
// Shared types and default sizing for the systolic array edge feeder.
package systolic_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWCollect,
      StWBurst,
      StGap,
      StIfmap,
      StDone
   } feeder_state_e;

   localparam int unsigned DEF_W_BITWIDTH     = 8;
   localparam int unsigned DEF_IFMAP_BITWIDTH = 16;
   localparam int unsigned DEF_W_LEN          = 16;
   localparam int unsigned DEF_IFMAP_GAP      = 16;
   localparam int unsigned DEF_LEN_BITWIDTH   = 16;

   // Width able to hold max(a, b) inclusive.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/feeder_wbuf.sv
// Weight staging register file: written in collect order, read back in the same order for the burst.
module feeder_wbuf
   import systolic_pkg::*;
#(
   parameter int unsigned W_LEN      = DEF_W_LEN,
   parameter int unsigned W_BITWIDTH = DEF_W_BITWIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_clr,
   input  logic                  wr_en,
   input  logic [W_BITWIDTH-1:0] wr_data,
   input  logic                  rd_clr,
   input  logic                  rd_en,
   output logic [W_BITWIDTH-1:0] rd_data
);

   localparam int unsigned PTR_W = (W_LEN > 1) ? $clog2(W_LEN) : 1;

   logic [W_BITWIDTH-1:0] mem [W_LEN];
   logic [PTR_W-1:0]      wr_ptr_q;
   logic [PTR_W-1:0]      rd_ptr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (wr_clr)     wr_ptr_q <= '0;
         else if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (rd_clr)     rd_ptr_q <= '0;
         else if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q] <= wr_data;
   end

   assign rd_data = mem[rd_ptr_q];

endmodule

// File: rtl/systolic_feeder.sv
// Array-edge feeder: collects a full weight set, bursts it contiguously, idles for the gap,
// then streams ifmap beats. Weight and ifmap enables are never high together.
module systolic_feeder
   import systolic_pkg::*;
#(
   parameter int unsigned W_BITWIDTH     = DEF_W_BITWIDTH,
   parameter int unsigned IFMAP_BITWIDTH = DEF_IFMAP_BITWIDTH,
   parameter int unsigned W_LEN          = DEF_W_LEN,
   parameter int unsigned IFMAP_GAP      = DEF_IFMAP_GAP,
   parameter int unsigned LEN_BITWIDTH   = DEF_LEN_BITWIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [LEN_BITWIDTH-1:0]   ifmap_len,
   input  logic                      w_valid,
   input  logic [W_BITWIDTH-1:0]     w_data,
   output logic                      w_ready,
   input  logic                      ifmap_valid,
   input  logic [IFMAP_BITWIDTH-1:0] ifmap_data,
   output logic                      ifmap_ready,
   output logic                      w_enable_out,
   output logic [W_BITWIDTH-1:0]     w_data_out,
   output logic                      ifmap_enable_out,
   output logic [IFMAP_BITWIDTH-1:0] ifmap_data_out,
   output logic                      busy,
   output logic                      done
);

   localparam int unsigned CNT_W = cnt_width(W_LEN, IFMAP_GAP);

   feeder_state_e           state_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [LEN_BITWIDTH-1:0] len_q;
   logic [LEN_BITWIDTH-1:0] beats_q;
   logic [W_BITWIDTH-1:0]   rd_data;
   logic                    w_hs;
   logic                    i_hs;

   assign w_ready     = (state_q == StWCollect);
   assign ifmap_ready = (state_q == StIfmap) && (beats_q != len_q);
   assign w_hs        = w_valid & w_ready;
   assign i_hs        = ifmap_valid & ifmap_ready;

   // Write pointer rewinds while idle, read pointer while collecting.
   feeder_wbuf #(
      .W_LEN      (W_LEN),
      .W_BITWIDTH (W_BITWIDTH)
   ) u_wbuf (
      .clk     (clk),
      .rst     (rst),
      .wr_clr  (state_q == StIdle),
      .wr_en   (w_hs),
      .wr_data (w_data),
      .rd_clr  (state_q == StWCollect),
      .rd_en   (state_q == StWBurst),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= StIdle;
         cnt_q            <= '0;
         len_q            <= '0;
         beats_q          <= '0;
         w_enable_out     <= 1'b0;
         w_data_out       <= '0;
         ifmap_enable_out <= 1'b0;
         ifmap_data_out   <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
      end else begin
         w_enable_out     <= 1'b0;
         ifmap_enable_out <= 1'b0;
         done             <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  len_q   <= ifmap_len;
                  cnt_q   <= '0;
                  busy    <= 1'b1;
                  state_q <= StWCollect;
               end
            end
            StWCollect: begin
               if (w_hs) begin
                  if (cnt_q == CNT_W'(W_LEN - 1)) begin
                     cnt_q   <= '0;
                     state_q <= StWBurst;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            StWBurst: begin
               w_enable_out <= 1'b1;
               w_data_out   <= rd_data;
               if (cnt_q == CNT_W'(W_LEN - 1)) begin
                  cnt_q   <= '0;
                  state_q <= StGap;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            StGap: begin
               // Gap state spans IFMAP_GAP cycles; the last weight beat is visible in its first.
               if (cnt_q == CNT_W'(IFMAP_GAP - 1)) begin
                  cnt_q   <= '0;
                  beats_q <= '0;
                  if (len_q == '0) begin
                     done    <= 1'b1;
                     state_q <= StDone;
                  end else begin
                     state_q <= StIfmap;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            StIfmap: begin
               if (i_hs) begin
                  ifmap_enable_out <= 1'b1;
                  ifmap_data_out   <= ifmap_data;
                  beats_q          <= beats_q + LEN_BITWIDTH'(1);
                  if (beats_q == len_q - LEN_BITWIDTH'(1)) begin
                     done    <= 1'b1;
                     state_q <= StDone;
                  end
               end
            end
            StDone: begin
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifndef SYNTHESIS
   logic [CNT_W-1:0] w_run_q;

   always_ff @(posedge clk) begin
      if (rst)               w_run_q <= '0;
      else if (w_enable_out) w_run_q <= w_run_q + CNT_W'(1);
      else                   w_run_q <= '0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(w_enable_out && ifmap_enable_out))
            else $error("weight and ifmap enables high together");
         assert (!(w_enable_out && (w_run_q == CNT_W'(W_LEN))))
            else $error("weight enable run too long");
         assert (w_enable_out || (w_run_q == '0) || (w_run_q == CNT_W'(W_LEN)))
            else $error("weight enable run too short");
      end
   end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized bench for systolic_feeder against a cycle-timeline reference model.
module tb_systolic_feeder;
   import systolic_pkg::*;

   localparam int WB    = 8;
   localparam int IB    = 16;
   localparam int WL    = 16;
   localparam int GAP   = 16;
   localparam int LB    = 16;
   localparam int NJOBS = 8;
   localparam int RST_JOB = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [LB-1:0] ifmap_len;
   logic          w_valid;
   logic [WB-1:0] w_data;
   logic          w_ready;
   logic          ifmap_valid;
   logic [IB-1:0] ifmap_data;
   logic          ifmap_ready;
   logic          w_enable_out;
   logic [WB-1:0] w_data_out;
   logic          ifmap_enable_out;
   logic [IB-1:0] ifmap_data_out;
   logic          busy;
   logic          done;

   always #5 clk = ~clk;

   systolic_feeder #(
      .W_BITWIDTH     (WB),
      .IFMAP_BITWIDTH (IB),
      .W_LEN          (WL),
      .IFMAP_GAP      (GAP),
      .LEN_BITWIDTH   (LB)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .ifmap_len        (ifmap_len),
      .w_valid          (w_valid),
      .w_data           (w_data),
      .w_ready          (w_ready),
      .ifmap_valid      (ifmap_valid),
      .ifmap_data       (ifmap_data),
      .ifmap_ready      (ifmap_ready),
      .w_enable_out     (w_enable_out),
      .w_data_out       (w_data_out),
      .ifmap_enable_out (ifmap_enable_out),
      .ifmap_data_out   (ifmap_data_out),
      .busy             (busy),
      .done             (done)
   );

   int cyc = 0;
   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   // Job plan: mode 0 = directed values, 1 = toggling w_valid, 2 = ifmap pattern, 3 = random.
   int plan_len [NJOBS] = '{4, 5, 3, 0, 6, 2, 7, 1};
   int plan_mode[NJOBS] = '{0, 1, 2, 3, 3, 3, 3, 3};
   bit ipat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

   // Reference model: event cycles of the current job.
   bit            job_on = 0;
   bit            a_set = 0;
   int            a_cyc = 0;
   int            done_cyc = -1;
   int            wacc = 0;
   int            iacc = 0;
   int            len_m = 0;
   int            jobidx = 0;
   logic [WB-1:0] wq[$];
   logic [WB-1:0] last_w = '0;
   logic [IB-1:0] last_i = '0;
   bit            prev_ihs = 0;
   logic [IB-1:0] prev_idata = '0;

   initial begin
      bit e_wready, e_wen, e_iready, e_ien, e_done, e_busy;
      int ifs, mode;

      rst = 1'b1;
      start = 1'b0;
      ifmap_len = '0;
      w_valid = 1'b0;
      w_data = '0;
      ifmap_valid = 1'b0;
      ifmap_data = '0;
      repeat (3) @(posedge clk);

      while (jobidx < NJOBS && cyc < 20000) begin
         @(posedge clk);
         #1;
         cyc++;

         // Expected outputs for this cycle, derived from the job's event times.
         ifs      = a_cyc + WL + 1 + GAP;
         e_wready = job_on && (wacc < WL);
         e_wen    = job_on && a_set && (cyc >= a_cyc + 2) && (cyc <= a_cyc + WL + 1);
         if (e_wen) last_w = wq[cyc - a_cyc - 2];
         e_iready = job_on && a_set && (cyc >= ifs) && (iacc < len_m);
         e_ien    = prev_ihs;
         if (prev_ihs) last_i = prev_idata;
         e_done   = job_on && (cyc == done_cyc);
         e_busy   = job_on;

         check("w_ready",     32'(w_ready),          32'(e_wready));
         check("ifmap_ready", 32'(ifmap_ready),      32'(e_iready));
         check("w_enable",    32'(w_enable_out),     32'(e_wen));
         check("w_data_out",  32'(w_data_out),       32'(last_w));
         check("ifmap_en",    32'(ifmap_enable_out), 32'(e_ien));
         check("ifmap_data",  32'(ifmap_data_out),   32'(last_i));
         check("busy",        32'(busy),             32'(e_busy));
         check("done",        32'(done),             32'(e_done));

         // Stimulus for this cycle.
         mode = (jobidx < NJOBS) ? plan_mode[jobidx] : 3;
         rst  = (jobidx == RST_JOB) && job_on && a_set && (cyc == a_cyc + 9);
         if (rst) begin
            start = 1'b0;
         end else if (!job_on) begin
            start     = ($urandom_range(0, 2) == 0);
            ifmap_len = LB'(plan_len[jobidx]);
         end else begin
            start     = ($urandom_range(0, 3) == 0);
            ifmap_len = LB'($urandom);
         end
         case (mode)
            0:       w_valid = 1'b1;
            1:       w_valid = cyc[0];
            default: w_valid = 1'($urandom);
         endcase
         w_data = (mode == 0) ? WB'(wacc + 1) : WB'($urandom);
         if (mode == 0)
            ifmap_valid = 1'b1;
         else if (mode == 2 && a_set && cyc >= ifs && cyc < ifs + 5)
            ifmap_valid = ipat[cyc - ifs];
         else if (mode == 2 && a_set && cyc >= ifs)
            ifmap_valid = 1'b1;
         else
            ifmap_valid = 1'($urandom);
         ifmap_data = (mode == 0) ? IB'(16'h000A + iacc) : IB'($urandom);

         // Advance the model by this cycle's handshakes.
         if (rst) begin
            job_on   = 0;
            a_set    = 0;
            done_cyc = -1;
            prev_ihs = 0;
            last_w   = '0;
            last_i   = '0;
            jobidx++;
         end else begin
            prev_ihs   = e_iready && ifmap_valid;
            prev_idata = ifmap_data;
            if (e_wready && w_valid) begin
               wq.push_back(w_data);
               wacc++;
               if (wacc == WL) begin
                  a_set = 1;
                  a_cyc = cyc;
                  if (len_m == 0) done_cyc = cyc + WL + 1 + GAP;
               end
            end
            if (prev_ihs) begin
               iacc++;
               if (iacc == len_m) done_cyc = cyc + 1;
            end
            if (job_on && cyc == done_cyc) begin
               job_on = 0;
               a_set  = 0;
               jobidx++;
            end else if (!job_on && start) begin
               job_on   = 1;
               a_set    = 0;
               len_m    = int'(ifmap_len);
               wacc     = 0;
               iacc     = 0;
               done_cyc = -1;
               wq.delete();
            end
         end
      end

      if (jobidx < NJOBS) check("job_timeout", 32'(jobidx), 32'(NJOBS));

      // A few idle cycles after the last job: everything must stay quiet.
      start = 1'b0;
      rst   = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
         cyc++;
         check("idle_busy", 32'(busy), 32'(0));
         check("idle_wen",  32'(w_enable_out), 32'(0));
         check("idle_ien",  32'(ifmap_enable_out), 32'(0));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
